command_device_core: RTL and testbench

Parametrised next-generation command-controlled device: register file plus ALU executing externally supplied commands over a valid/ready interface, with carry/zero flags and a handshaked, time-limited port I/O channel. It sits between a command source (sequencer or host) and the peripheral port bus. It generalises the fixed 4-bit, unhandshaked device to configurable width, register count and port count, with port wait states and timeout.

---
 rtl/command_device_core_if.sv | 30 +++
 rtl/command_device_core.sv | 106 ++++++++++
 tb/tb_command_device_core.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/command_device_core_if.sv
// command_device_core_if: command channel and peripheral port bus of the command device core
interface command_device_core_if #(
  parameter int WIDTH = 4,
  parameter int NREGS = 8,
  parameter int NPORTS = 8
);
  localparam int RW = $clog2(NREGS);
  localparam int PW = $clog2(NPORTS);
  logic cmd_valid;
  logic cmd_ready;
  logic [3:0] cmd_op;
  logic [RW-1:0] cmd_rd;
  logic [RW-1:0] cmd_rs;
  logic [WIDTH-1:0] cmd_imm;
  logic [PW-1:0] port_id;
  logic port_read;
  logic port_write;
  logic [WIDTH-1:0] port_data;
  logic [WIDTH-1:0] port_data_in;
  logic port_ack;
  logic port_timeout;
  modport slave (
    input cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_imm, port_data_in, port_ack,
    output cmd_ready, port_id, port_read, port_write, port_data, port_timeout
  );
  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_imm, port_data_in, port_ack,
    input cmd_ready, port_id, port_read, port_write, port_data, port_timeout
  );
endinterface

// File: rtl/command_device_core.sv
// command_device_core: register file + ALU driven by valid/ready commands, with a handshaked, time-limited port channel
module command_device_core #(
  parameter int WIDTH = 4,
  parameter int NREGS = 8,
  parameter int NPORTS = 8,
  parameter int TIMEOUT = 15
) (
  input  logic clock,
  input  logic reset,
  command_device_core_if.slave bus,
  output logic [WIDTH-1:0] data_out,
  output logic carry_flag,
  output logic zero_flag,
  output logic cmd_illegal
);
  localparam int RW = $clog2(NREGS);
  localparam int PW = $clog2(NPORTS);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic {IDLE, PORT} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] regs [NREGS];
  logic [CW-1:0] count;
  logic [RW-1:0] dst;
  logic accept, is_io, expired, wr, cw, zw, c_nx;
  logic [WIDTH-1:0] a, b, res;
  assign bus.cmd_ready = state == IDLE && !reset;
  assign accept = bus.cmd_valid && bus.cmd_ready;
  assign is_io = bus.cmd_op == 4'd11 || bus.cmd_op == 4'd12;
  assign expired = count == CW'(TIMEOUT - 1);
  assign a = regs[bus.cmd_rd];
  assign b = regs[bus.cmd_rs];
  assign zw = wr || bus.cmd_op == 4'd13;
  always_comb begin
    wr = 1'b0;
    cw = 1'b0;
    res = a;
    c_nx = carry_flag;
    case (bus.cmd_op)
      4'd1: begin wr = 1'b1; res = bus.cmd_imm; end
      4'd2: begin wr = 1'b1; res = b; end
      4'd3: begin wr = 1'b1; cw = 1'b1; {c_nx, res} = {1'b0, a} + {1'b0, b}; end
      4'd4: begin wr = 1'b1; cw = 1'b1; {c_nx, res} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_flag}; end
      // the extra top bit of the difference is the borrow (rd < rs)
      4'd5, 4'd13: begin wr = bus.cmd_op == 4'd5; cw = 1'b1; {c_nx, res} = {1'b0, a} - {1'b0, b}; end
      4'd6: begin wr = 1'b1; cw = 1'b1; res = a & b; c_nx = 1'b0; end
      4'd7: begin wr = 1'b1; cw = 1'b1; res = a | b; c_nx = 1'b0; end
      4'd8: begin wr = 1'b1; cw = 1'b1; res = a ^ b; c_nx = 1'b0; end
      4'd9: begin wr = 1'b1; cw = 1'b1; {c_nx, res} = {a, 1'b0}; end
      4'd10: begin wr = 1'b1; cw = 1'b1; res = a >> 1; c_nx = a[0]; end
      default: ;
    endcase
  end
  always_comb begin
    state_nx = state == IDLE ? (accept && is_io ? PORT : IDLE) : (bus.port_ack || expired ? IDLE : PORT);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      regs <= '{default: '0};
      data_out <= '0;
      carry_flag <= 1'b0;
      zero_flag <= 1'b0;
      cmd_illegal <= 1'b0;
      count <= '0;
      dst <= '0;
      bus.port_id <= '0;
      bus.port_read <= 1'b0;
      bus.port_write <= 1'b0;
      bus.port_data <= '0;
      bus.port_timeout <= 1'b0;
    end else begin
      state <= state_nx;
      cmd_illegal <= accept && bus.cmd_op >= 4'd14;
      bus.port_timeout <= 1'b0;
      if (accept && wr) begin
        regs[bus.cmd_rd] <= res;
        data_out <= res;
      end
      if (accept && cw) carry_flag <= c_nx;
      if (accept && zw) zero_flag <= res == '0;
      if (accept && is_io) begin
        bus.port_id <= bus.cmd_imm[PW-1:0];
        bus.port_data <= bus.cmd_op == 4'd12 ? a : bus.port_data;
        bus.port_read <= bus.cmd_op == 4'd11;
        bus.port_write <= bus.cmd_op == 4'd12;
        dst <= bus.cmd_rd;
        count <= '0;
      end
      if (state == PORT) begin
        if (bus.port_ack) begin
          bus.port_read <= 1'b0;
          bus.port_write <= 1'b0;
          if (bus.port_read) begin
            regs[dst] <= bus.port_data_in;
            data_out <= bus.port_data_in;
            zero_flag <= bus.port_data_in == '0;
          end
        end else if (expired) begin
          bus.port_read <= 1'b0;
          bus.port_write <= 1'b0;
          bus.port_timeout <= 1'b1;
        end else count <= count + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_command_device_core.sv
// tb_command_device_core: scoreboard bench for command_device_core (WIDTH=4, NREGS=8, NPORTS=8, TIMEOUT=15)
module tb_command_device_core;
  localparam int TIMEOUT = 15;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [3:0] data_out;
  logic carry_flag, zero_flag, cmd_illegal;
  int asserts = 0;
  int fails = 0;
  typedef struct {logic [3:0] d; logic c; logic z; logic ill;} exp_t;
  exp_t sb[$];
  command_device_core_if #(.WIDTH(4), .NREGS(8), .NPORTS(8)) bus();
  command_device_core #(.WIDTH(4), .NREGS(8), .NPORTS(8), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .bus(bus), .data_out(data_out),
    .carry_flag(carry_flag), .zero_flag(zero_flag), .cmd_illegal(cmd_illegal)
  );
  always #5 clock = ~clock;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end
  task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs, input logic [3:0] imm);
    bus.cmd_valid = 1'b1;
    bus.cmd_op = op;
    bus.cmd_rd = rd;
    bus.cmd_rs = rs;
    bus.cmd_imm = imm;
  endtask
  task automatic pop_compare(input string name);
    exp_t e;
    e = sb.pop_front();
    asserts++;
    if ({data_out, carry_flag, zero_flag, cmd_illegal} !== {e.d, e.c, e.z, e.ill}) begin
      fails++;
      $display("FAIL %s: got d=%0d c=%b z=%b ill=%b, want d=%0d c=%b z=%b ill=%b",
               name, data_out, carry_flag, zero_flag, cmd_illegal, e.d, e.c, e.z, e.ill);
    end
  endtask
  task automatic alu_cmd(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs, input logic [3:0] imm,
                         input logic [3:0] ed, input logic ec, input logic ez, input logic eill);
    @(negedge clock);
    if (sb.size() > 0) pop_compare("alu_result");
    asserts++;
    if (bus.cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL alu_ready: cmd_ready=%b want 1", bus.cmd_ready);
    end
    issue(op, rd, rs, imm);
    sb.push_back('{ed, ec, ez, eill});
  endtask
  task automatic drain();
    @(negedge clock);
    if (sb.size() > 0) pop_compare("alu_result");
    bus.cmd_valid = 1'b0;
  endtask
  task automatic port_access(input bit is_in, input logic [2:0] rd, input logic [3:0] imm, input int ack_at,
                             input logic [3:0] din, input logic [3:0] exp_pd,
                             input logic [3:0] ed, input logic ec, input logic ez);
    int n;
    bit done;
    logic [2:0] id;
    n = 0;
    done = 1'b0;
    id = imm[2:0];
    @(negedge clock);
    issue(is_in ? 4'd11 : 4'd12, rd, 3'd0, imm);
    @(negedge clock);
    bus.cmd_valid = 1'b0;
    for (int k = 1; k <= TIMEOUT + 2 && !done; k++) begin
      if (bus.port_read || bus.port_write) begin
        n++;
        asserts++;
        if (bus.port_read !== is_in || bus.port_write !== !is_in || bus.port_id !== id ||
            bus.cmd_ready !== 1'b0 || bus.port_timeout !== 1'b0 || (!is_in && bus.port_data !== exp_pd)) begin
          fails++;
          $display("FAIL port_busy cycle %0d: rd=%b wr=%b id=%0d data=%0d ready=%b to=%b, want rd=%b wr=%b id=%0d data=%0d ready=0 to=0",
                   k, bus.port_read, bus.port_write, bus.port_id, bus.port_data, bus.cmd_ready, bus.port_timeout,
                   is_in, !is_in, id, exp_pd);
        end
        if (k == ack_at) begin
          bus.port_ack = 1'b1;
          bus.port_data_in = din;
        end
        @(negedge clock);
        bus.port_ack = 1'b0;
      end else done = 1'b1;
    end
    asserts++;
    if (n != (ack_at > 0 ? ack_at : TIMEOUT)) begin
      fails++;
      $display("FAIL port_cycles: strobe high %0d cycles, want %0d", n, ack_at > 0 ? ack_at : TIMEOUT);
    end
    asserts++;
    if (bus.cmd_ready !== 1'b1 || bus.port_timeout !== (ack_at == 0)) begin
      fails++;
      $display("FAIL port_end: ready=%b timeout=%b, want ready=1 timeout=%b", bus.cmd_ready, bus.port_timeout, ack_at == 0);
    end
    sb.push_back('{ed, ec, ez, 1'b0});
    pop_compare("port_result");
    @(negedge clock);
    asserts++;
    if (bus.port_timeout !== 1'b0) begin
      fails++;
      $display("FAIL timeout_pulse: port_timeout=%b one cycle later, want 0", bus.port_timeout);
    end
  endtask
  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      asserts++;
      if (bus.cmd_ready !== 1'b0) begin
        fails++;
        $display("FAIL reset_ready: cmd_ready=%b during reset, want 0", bus.cmd_ready);
      end
    end
    reset = 1'b0;
    @(negedge clock);
    asserts++;
    if ({data_out, carry_flag, zero_flag, cmd_illegal, bus.port_id, bus.port_read, bus.port_write,
         bus.port_data, bus.port_timeout} !== 18'd0 || bus.cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_state: d=%0d c=%b z=%b ill=%b id=%0d r=%b w=%b pd=%0d to=%b ready=%b, want all 0 and ready=1",
               data_out, carry_flag, zero_flag, cmd_illegal, bus.port_id, bus.port_read, bus.port_write,
               bus.port_data, bus.port_timeout, bus.cmd_ready);
    end
  endtask
  task automatic test_back_to_back();
    alu_cmd(4'd1, 3'd1, 3'd0, 4'd9, 4'd9, 1'b0, 1'b0, 1'b0);
    alu_cmd(4'd1, 3'd2, 3'd0, 4'd8, 4'd8, 1'b0, 1'b0, 1'b0);
    alu_cmd(4'd3, 3'd1, 3'd2, 4'd0, 4'd1, 1'b1, 1'b0, 1'b0);
    alu_cmd(4'd4, 3'd1, 3'd2, 4'd0, 4'd10, 1'b0, 1'b0, 1'b0);
    drain();
  endtask
  task automatic test_cmp_sub_shr_illegal();
    alu_cmd(4'd13, 3'd1, 3'd1, 4'd0, 4'd10, 1'b0, 1'b1, 1'b0);
    alu_cmd(4'd5, 3'd2, 3'd1, 4'd0, 4'd14, 1'b1, 1'b0, 1'b0);
    alu_cmd(4'd10, 3'd2, 3'd0, 4'd0, 4'd7, 1'b0, 1'b0, 1'b0);
    alu_cmd(4'd15, 3'd2, 3'd1, 4'd3, 4'd7, 1'b0, 1'b0, 1'b1);
    drain();
    @(negedge clock);
    asserts++;
    if (cmd_illegal !== 1'b0) begin
      fails++;
      $display("FAIL illegal_pulse: cmd_illegal=%b two cycles after accept, want 0", cmd_illegal);
    end
  endtask
  task automatic test_port_out();
    port_access(1'b0, 3'd2, 4'd5, 3, 4'd0, 4'd7, 4'd7, 1'b0, 1'b0);
  endtask
  task automatic test_port_in_timeout();
    port_access(1'b1, 3'd4, 4'd2, 0, 4'd0, 4'd0, 4'd7, 1'b0, 1'b0);
    port_access(1'b1, 3'd4, 4'd2, TIMEOUT, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
  endtask
  task automatic test_reset_mid_access();
    alu_cmd(4'd1, 3'd1, 3'd0, 4'd6, 4'd6, 1'b0, 1'b0, 1'b0);
    drain();
    @(negedge clock);
    issue(4'd11, 3'd4, 3'd0, 4'd2);
    @(negedge clock);
    bus.cmd_valid = 1'b0;
    @(negedge clock);
    asserts++;
    if (bus.port_read !== 1'b1) begin
      fails++;
      $display("FAIL mid_in_strobe: port_read=%b in PORT cycle 2, want 1", bus.port_read);
    end
    reset = 1'b1;
    @(negedge clock);
    asserts++;
    if ({bus.port_read, bus.port_write, bus.port_timeout, bus.cmd_ready, data_out, carry_flag, zero_flag} !== 10'd0) begin
      fails++;
      $display("FAIL mid_reset_state: r=%b w=%b to=%b ready=%b d=%0d c=%b z=%b, want all 0",
               bus.port_read, bus.port_write, bus.port_timeout, bus.cmd_ready, data_out, carry_flag, zero_flag);
    end
    reset = 1'b0;
    @(negedge clock);
    asserts++;
    if (bus.cmd_ready !== 1'b1 || bus.port_timeout !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_release: ready=%b to=%b, want ready=1 to=0", bus.cmd_ready, bus.port_timeout);
    end
    alu_cmd(4'd2, 3'd5, 3'd1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    alu_cmd(4'd7, 3'd5, 3'd2, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    drain();
  endtask
  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 4'd0;
    bus.cmd_rd = 3'd0;
    bus.cmd_rs = 3'd0;
    bus.cmd_imm = 4'd0;
    bus.port_ack = 1'b0;
    bus.port_data_in = 4'd0;
    test_reset();
    test_back_to_back();
    test_cmp_sub_shr_illegal();
    test_port_out();
    test_port_in_timeout();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
